// File: rtl/viterbi_pkg.sv
// Shared constants, metric type and trellis helper for the
// rate-1/2 K=5 hard-decision Viterbi decoder.
package viterbi_pkg;

    localparam int K        = 5;
    localparam int NSTATES  = 16;
    localparam int PM_W_DEF = 6;

    localparam logic [K-1:0] G0_DEF = 5'b11101;
    localparam logic [K-1:0] G1_DEF = 5'b10011;

    typedef logic [PM_W_DEF-1:0] pm_t;
    typedef logic [1:0]          bm_t;

    // Symbol the encoder emits when bit b enters from state s.
    function automatic logic [1:0] exp_sym(
        input logic [K-1:0] g0,
        input logic [K-1:0] g1,
        input logic [3:0]   s,
        input logic         b
    );
        logic [K-1:0] r;
        r = {s, b};
        return {^(r & g1), ^(r & g0)};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// One trellis state: add-compare-select with metric
// normalisation and register-exchange survivor.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int         PM_W     = PM_W_DEF,
    parameter int         TB_DEPTH = 32,
    parameter logic [3:0] NS       = 4'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                norm_i,
    input  logic [PM_W-1:0]     pm0_i,
    input  logic [PM_W-1:0]     pm1_i,
    input  bm_t                 bm0_i,
    input  bm_t                 bm1_i,
    input  logic [TB_DEPTH-1:0] surv0_i,
    input  logic [TB_DEPTH-1:0] surv1_i,
    output logic [PM_W-1:0]     pm_o,
    output logic [TB_DEPTH-1:0] surv_o
);

    localparam logic [PM_W-1:0] PM_RST =
        (NS == 4'd0) ? '0 : {2'b01, {(PM_W-2){1'b0}}};

    logic [PM_W-1:0]     c0, c1, pm_d, pm_q;
    logic [TB_DEPTH-1:0] ssel, surv_d, surv_q;
    logic                sel;

    always_comb begin
        c0 = pm0_i + PM_W'(bm0_i);
        c1 = pm1_i + PM_W'(bm1_i);
        if (norm_i) begin
            c0[PM_W-1] = 1'b0;
            c1[PM_W-1] = 1'b0;
        end
        // Strict compare: ties resolve to the x=0 predecessor.
        sel    = c1 < c0;
        pm_d   = sel ? c1 : c0;
        ssel   = sel ? surv1_i : surv0_i;
        surv_d = {ssel[TB_DEPTH-2:0], NS[0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q   <= PM_RST;
            surv_q <= '0;
        end else if (en_i) begin
            pm_q   <= pm_d;
            surv_q <= surv_d;
        end
    end

    assign pm_o   = pm_q;
    assign surv_o = surv_q;

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder: 16 ACS units, best-state
// search and the registered decoded-bit output.
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int           PM_W     = PM_W_DEF,
    parameter int           TB_DEPTH = 32,
    parameter logic [K-1:0] G0       = G0_DEF,
    parameter logic [K-1:0] G1       = G1_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] code_in,
    input  logic       code_valid,
    output logic       data_out,
    output logic       data_valid
);

    localparam int CW = $clog2(TB_DEPTH + 1);

    logic [PM_W-1:0]     pm   [NSTATES];
    logic [TB_DEPTH-1:0] surv [NSTATES];
    logic [NSTATES-1:0]  msb;
    logic                norm;
    logic [3:0]          best;
    logic [PM_W-1:0]     best_pm;
    logic [CW-1:0]       cnt_q;
    logic                data_out_q, data_valid_q;

    assign norm = &msb;

    for (genvar g = 0; g < NSTATES; g++) begin : g_st
        localparam logic [3:0] NS = 4'(g);
        localparam logic [3:0] P0 = {1'b0, NS[3:1]};
        localparam logic [3:0] P1 = {1'b1, NS[3:1]};
        localparam bm_t E0 = exp_sym(G0, G1, P0, NS[0]);
        localparam bm_t E1 = exp_sym(G0, G1, P1, NS[0]);

        bm_t d0, d1, bm0, bm1;
        assign d0  = code_in ^ E0;
        assign d1  = code_in ^ E1;
        assign bm0 = {1'b0, d0[0]} + {1'b0, d0[1]};
        assign bm1 = {1'b0, d1[0]} + {1'b0, d1[1]};
        assign msb[g] = pm[g][PM_W-1];

        viterbi_acs #(
            .PM_W     (PM_W),
            .TB_DEPTH (TB_DEPTH),
            .NS       (NS)
        ) u_acs (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (code_valid),
            .norm_i  (norm),
            .pm0_i   (pm[P0]),
            .pm1_i   (pm[P1]),
            .bm0_i   (bm0),
            .bm1_i   (bm1),
            .surv0_i (surv[P0]),
            .surv1_i (surv[P1]),
            .pm_o    (pm[g]),
            .surv_o  (surv[g])
        );
    end

    always_comb begin
        best    = 4'd0;
        best_pm = pm[0];
        for (int i = 1; i < NSTATES; i++) begin
            if (pm[i] < best_pm) begin
                best_pm = pm[i];
                best    = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
        end else if (code_valid) begin
            data_out_q   <= surv[best][TB_DEPTH-1];
            data_valid_q <= (cnt_q == CW'(TB_DEPTH));
            if (cnt_q != CW'(TB_DEPTH)) cnt_q <= cnt_q + 1'b1;
        end else begin
            data_valid_q <= 1'b0;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench: a reference encoder feeds the decoder and
// the source bits are compared against each data_valid pulse.
module tb_viterbi_decoder;

    localparam int TBD = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] code_in = 2'b00;
    logic       code_valid = 1'b0;
    logic       data_out, data_valid;

    int   checks = 0;
    int   failures = 0;
    bit   exp_q[$];
    logic [3:0] enc_s = 4'd0;
    int   acc = 0;
    bit   first_pending = 1'b0;
    bit   lb_bits [1000];

    always #5 clk = ~clk;

    viterbi_decoder #(
        .PM_W     (6),
        .TB_DEPTH (TBD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] sym,
                        input string tag);
        bit e;
        code_valid = v;
        code_in    = sym;
        @(posedge clk);
        #1;
        if (v) acc++;
        if (data_valid) begin
            check({tag, "_valid_after_accept"}, 32'(v), 32'd1);
            if (first_pending) begin
                check("first_valid_latency", 32'(acc), 32'(TBD + 1));
                first_pending = 1'b0;
            end
            check({tag, "_queue_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
            check(tag, 32'(data_out), 32'(e));
        end
    endtask

    task automatic send_bit(input bit b, input logic [1:0] flip,
                            input int duty, input string tag);
        logic [4:0] r;
        logic [1:0] sym;
        while (int'($urandom_range(99)) >= duty)
            step(1'b0, 2'($urandom), tag);
        r     = {enc_s, b};
        sym   = {^(r & 5'b10011), ^(r & 5'b11101)};
        enc_s = {enc_s[2:0], b};
        exp_q.push_back(b);
        step(1'b1, sym ^ flip, tag);
    endtask

    task automatic do_reset();
        code_valid = 1'b0;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        enc_s = 4'd0;
        acc   = 0;
    endtask

    task automatic end_phase(input string tag);
        check({tag, "_tail"}, 32'(exp_q.size()), 32'(TBD));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_data_valid", 32'(data_valid), 32'd0);
        rst_n = 1'b1;

        // Impulse: symbols 11,10,01,01,11 then 00.
        send_bit(1'b1, 2'b00, 100, "impulse");
        for (int i = 0; i < 64; i++) send_bit(1'b0, 2'b00, 100, "impulse");
        end_phase("impulse");

        do_reset();
        for (int i = 0; i < 1000; i++) begin
            lb_bits[i] = 1'($urandom);
            send_bit(lb_bits[i], 2'b00, 100, "loopback");
        end
        end_phase("loopback");

        do_reset();
        for (int i = 0; i < 1000; i++)
            send_bit(lb_bits[i], 2'b00, 40, "gaps");
        end_phase("gaps");

        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [1:0] f;
            f = (i % 12 == 5) ? (((i / 12) % 2) ? 2'b10 : 2'b01) : 2'b00;
            send_bit(1'($urandom), f, 100, "err12");
        end
        end_phase("err12");

        do_reset();
        for (int i = 0; i < 200; i++) begin
            logic [1:0] f;
            f = (i == 100 || i == 108) ? 2'b01 : (i == 104) ? 2'b10 : 2'b00;
            send_bit(1'($urandom), f, 100, "err3");
        end
        end_phase("err3");

        do_reset();
        for (int i = 0; i < 5000; i++) begin
            logic [1:0] f;
            f = (i % 8 == 3) ? (((i / 8) % 2) ? 2'b10 : 2'b01) : 2'b00;
            send_bit(1'b1, f, 100, "norm");
        end
        end_phase("norm");

        do_reset();
        for (int i = 0; i < 300; i++)
            send_bit(1'($urandom), 2'b00, 100, "pre_rst");
        code_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("midrst_data_valid", 32'(data_valid), 32'd0);
        check("midrst_data_out", 32'(data_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        enc_s = 4'd0;
        acc   = 0;
        first_pending = 1'b1;
        for (int i = 0; i < 100; i++)
            send_bit(1'($urandom), 2'b00, 100, "post_rst");
        check("post_rst_valid_seen", 32'(first_pending), 32'd0);
        end_phase("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/viterbi_decoder.md
Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the team's rate-1/2, K=5 convolutional code (g0=5'b11101, g1=5'b10011).
- Receives one 2-bit code symbol per accepted cycle and recovers the original data bit stream.
- Sits at the receive end of the channel, opposite the convolutional encoder.
- Uses 16-state add-compare-select (ACS) with register-exchange survivor memory.

Parameters:
- PM_W, 6, path-metric width in bits. Must be at least 5.
- TB_DEPTH, 32, survivor register length per state, equal to the decision depth. Must be at least 20.
- G0, 5'b11101, generator polynomial for code_in[0]. Bit 0 taps the newest data bit.
- G1, 5'b10011, generator polynomial for code_in[1].

Ports:
- clk  in  1  clock. All state updates on the rising edge, giving half-cycle margin against the encoder's falling-edge launch.
- rst_n  in  1  reset, asynchronous, active-low.
- code_in  in  2  received symbol. [0] is the G0 output, [1] is the G1 output.
- code_valid  in  1  code_in is accepted on a rising edge with code_valid=1.
- data_out  out  1  decoded data bit.
- data_valid  out  1  one-cycle pulse qualifying data_out.

Behaviour:
- Trellis:
  - State s[3:0] holds the 4 most recent input bits; s[0] is the newest.
  - Input b moves s to ns={s[2:0],b}.
  - Branch register r={s,b}. Expected symbol: e[0]=^(r&G0), e[1]=^(r&G1).
  - Predecessors of ns are {0,ns[3:1]} and {1,ns[3:1]}; the decided bit is ns[0].
- Branch metric: Hamming distance between code_in and e, range 0..2.
- ACS, per state, on every accepted symbol:
  - cand_x = pm[{x,ns[3:1]}] + bm.
  - Choose the smaller candidate; on a tie choose x=0.
  - pm[ns] <= chosen value; surv[ns] <= {surv[pred][TB_DEPTH-2:0], ns[0]}.
- Normalisation: if all 16 metrics entering the ACS have their MSB set, clear the MSB of every candidate in that same update. Arithmetic is unsigned PM_W bits and must never wrap otherwise.
- Reset values:
  - pm[0]=0; pm[1..15]=2^(PM_W-2).
  - All survivors 0, symbol counter 0.
  - data_out=0, data_valid=0.
- Output selection:
  - best = index of the minimum current registered pm, lowest index on tie.
  - On an accepting edge: data_out <= surv[best][TB_DEPTH-1]; data_valid <= (count >= TB_DEPTH).
  - count is the number of symbols accepted before this edge, saturating at TB_DEPTH.
- Latency: data bit k (0-based symbol index since reset) is emitted on the edge accepting symbol k+TB_DEPTH. data_valid is high the cycle after that edge.
- code_valid=0: metrics, survivors, count and data_out hold; data_valid <= 0.
- Gaps of any length are transparent. The output sequence depends only on the accepted symbol sequence.
- Reset mid-stream: all state returns to reset values immediately (asynchronous). No output until TB_DEPTH new symbols are accepted.
- End-to-end with the encoder: decoded stream = encoder data_in delayed by one bit (the encoder's input register contributes a leading 0).

Decomposition:
- Shared package holds:
  - K=5, NSTATES=16, default G0/G1.
  - A function returning the expected 2-bit symbol for (state, bit).
  - The metric type width.
- One natural sub-module, viterbi_acs: one state's compare/select, normalisation and survivor shift. Instantiate 16 times with generate.
- Best-state search and the output register stay in the top level.

Test Plan:
- Impulse: symbols 11,10,01,01,11 then 00 continuously (written code_in[1:0]) -> after TB_DEPTH latency data_out sequence is 1,0,0,0,... with no other 1s.
- Loopback: instantiate the encoder, drive 1000 random bits with code_valid=1 -> data_out equals the encoder input delayed one bit, with zero mismatches.
- Error correction:
  - Invert one code bit every 12 symbols on a random stream -> zero decoded errors.
  - Invert 3 bits within one 10-symbol window -> zero errors.
- Gaps: random code_valid duty 40% on the loopback stream -> identical decoded bits versus the gap-free run; data_valid pulses only after accepted symbols.
- Normalisation: 5000 symbols of all-ones input with a bit error every 8 symbols -> no metric wrap (assert via bind checker) and zero decoded errors.
- Reset mid-stream: assert rst_n low for 1 cycle at symbol 300 -> data_valid=0, data_out=0 immediately; first new data_valid arrives exactly TB_DEPTH accepted symbols later and decodes correctly.
